pixeladdress_to_screencharindex: RTL and testbench

Inverse of the character-cell address mapping used by the text overlay. It accepts a linear framebuffer pixel address, where address = y·640 + x. It returns the text-cell index (0–255) of the 32×8 character grid that starts at scanline 240, plus the glyph-local row and column of that pixel. It sits between the VGA scan/pointer logic and the character RAM, and is used for glyph lookup and cursor hit-testing. The block is a multi-cycle iterative divider with a valid/ready handshake on both sides.

---
 rtl/pixeladdress_to_screencharindex_if.sv | 37 +++
 rtl/pixeladdress_to_screencharindex.sv | 196 +++++++++++++++++++
 tb/tb_pixeladdress_to_screencharindex.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/pixeladdress_to_screencharindex_if.sv
// Handshake bundle for the pixel-address to text-cell converter.
// Request: in_valid/in_ready/address; response: out_valid/out_ready/results.
interface pixeladdress_to_screencharindex_if;
    logic        in_valid;
    logic        in_ready;
    logic [18:0] address;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] count;
    logic [4:0]  glyph_row;
    logic [4:0]  glyph_col;
    logic        in_text;

    modport master (
        output in_valid,
        output address,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  count,
        input  glyph_row,
        input  glyph_col,
        input  in_text
    );

    modport slave (
        input  in_valid,
        input  address,
        input  out_ready,
        output in_ready,
        output out_valid,
        output count,
        output glyph_row,
        output glyph_col,
        output in_text
    );
endinterface

// File: rtl/pixeladdress_to_screencharindex.sv
// Linear pixel address -> text-cell index and glyph-local row/column.
// Iterative restoring dividers: 19 cycles for y/x, 10 cycles for cells.
module pixeladdress_to_screencharindex #(
    parameter int SCREEN_WIDTH = 640,
    parameter int CHAR_WIDTH   = 20,
    parameter int CHAR_HEIGHT  = 30,
    parameter int TEXT_TOP     = 240,
    parameter int TEXT_COLS    = 32,
    parameter int TEXT_ROWS    = 8
) (
    input logic clock,
    input logic reset,
    pixeladdress_to_screencharindex_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        DIV_Y,
        DIV_CELL,
        DONE
    } state_t;

    localparam logic [10:0] SW      = 11'(SCREEN_WIDTH);
    localparam logic [5:0]  CH      = 6'(CHAR_HEIGHT);
    localparam logic [5:0]  CW      = 6'(CHAR_WIDTH);
    localparam logic [9:0]  TOP     = 10'(TEXT_TOP);
    localparam logic [9:0]  BOT     = 10'(TEXT_TOP + TEXT_ROWS * CHAR_HEIGHT);
    localparam logic [31:0] OUTSIDE = 32'(TEXT_COLS * TEXT_ROWS);
    localparam logic [4:0]  Y_LAST  = 5'd18;
    localparam logic [4:0]  C_LAST  = 5'd9;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [18:0] div_q, div_d;
    logic [9:0]  rem_y_q, rem_y_d;
    logic [9:0]  quo_y_q, quo_y_d;
    logic [9:0]  ydiv_q, ydiv_d;
    logic [9:0]  xdiv_q, xdiv_d;
    logic [4:0]  rem_r_q, rem_r_d;
    logic [4:0]  rem_c_q, rem_c_d;
    logic [2:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic        in_text_q, in_text_d;
    logic [31:0] count_q, count_d;
    logic [4:0]  grow_q, grow_d;
    logic [4:0]  gcol_q, gcol_d;

    logic [10:0] trial_y;
    logic        ge_y;
    logic [9:0]  rem_y_n;
    logic [9:0]  quo_y_n;
    logic [5:0]  trial_r;
    logic        ge_r;
    logic [4:0]  rem_r_n;
    logic [2:0]  row_n;
    logic [5:0]  trial_c;
    logic        ge_c;
    logic [4:0]  rem_c_n;
    logic [4:0]  col_n;

    // One restoring step of each divider; upper quotient bits are always zero
    // for in-range operands, so the quotient registers are kept narrow.
    always_comb begin
        trial_y = {rem_y_q, div_q[18]};
        ge_y    = trial_y >= SW;
        rem_y_n = ge_y ? 10'(trial_y - SW) : trial_y[9:0];
        quo_y_n = {quo_y_q[8:0], ge_y};
        trial_r = {rem_r_q, ydiv_q[9]};
        ge_r    = trial_r >= CH;
        rem_r_n = ge_r ? 5'(trial_r - CH) : trial_r[4:0];
        row_n   = {row_q[1:0], ge_r};
        trial_c = {rem_c_q, xdiv_q[9]};
        ge_c    = trial_c >= CW;
        rem_c_n = ge_c ? 5'(trial_c - CW) : trial_c[4:0];
        col_n   = {col_q[3:0], ge_c};
    end

    // Next-state and datapath sequencing for the four-state controller.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        rem_y_d   = rem_y_q;
        quo_y_d   = quo_y_q;
        ydiv_d    = ydiv_q;
        xdiv_d    = xdiv_q;
        rem_r_d   = rem_r_q;
        rem_c_d   = rem_c_q;
        row_d     = row_q;
        col_d     = col_q;
        in_text_d = in_text_q;
        count_d   = count_q;
        grow_d    = grow_q;
        gcol_d    = gcol_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    div_d   = bus.address;
                    rem_y_d = '0;
                    quo_y_d = '0;
                    cnt_d   = '0;
                    state_d = DIV_Y;
                end
            end
            DIV_Y: begin
                div_d   = {div_q[17:0], 1'b0};
                rem_y_d = rem_y_n;
                quo_y_d = quo_y_n;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == Y_LAST) begin
                    in_text_d = (quo_y_n >= TOP) && (quo_y_n < BOT);
                    ydiv_d    = quo_y_n - TOP;
                    xdiv_d    = rem_y_n;
                    rem_r_d   = '0;
                    rem_c_d   = '0;
                    row_d     = '0;
                    col_d     = '0;
                    cnt_d     = '0;
                    state_d   = DIV_CELL;
                end
            end
            DIV_CELL: begin
                ydiv_d  = {ydiv_q[8:0], 1'b0};
                xdiv_d  = {xdiv_q[8:0], 1'b0};
                rem_r_d = rem_r_n;
                rem_c_d = rem_c_n;
                row_d   = row_n;
                col_d   = col_n;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == C_LAST) begin
                    if (in_text_q) begin
                        count_d = 32'(row_n) * 32'(TEXT_COLS) + 32'(col_n);
                        grow_d  = rem_r_n;
                        gcol_d  = rem_c_n;
                    end else begin
                        count_d = OUTSIDE;
                        grow_d  = '0;
                        gcol_d  = '0;
                    end
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            rem_y_q   <= '0;
            quo_y_q   <= '0;
            ydiv_q    <= '0;
            xdiv_q    <= '0;
            rem_r_q   <= '0;
            rem_c_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            in_text_q <= 1'b0;
            count_q   <= '0;
            grow_q    <= '0;
            gcol_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            rem_y_q   <= rem_y_d;
            quo_y_q   <= quo_y_d;
            ydiv_q    <= ydiv_d;
            xdiv_q    <= xdiv_d;
            rem_r_q   <= rem_r_d;
            rem_c_q   <= rem_c_d;
            row_q     <= row_d;
            col_q     <= col_d;
            in_text_q <= in_text_d;
            count_q   <= count_d;
            grow_q    <= grow_d;
            gcol_q    <= gcol_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.count     = count_q;
    assign bus.glyph_row = grow_q;
    assign bus.glyph_col = gcol_q;
    assign bus.in_text   = in_text_q;

endmodule

// File: tb/tb_pixeladdress_to_screencharindex.sv
// Bench for the pixel-address to text-cell converter.
// Randomized addresses are checked against an arithmetic reference model.
module tb_pixeladdress_to_screencharindex;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    pixeladdress_to_screencharindex_if bus ();

    pixeladdress_to_screencharindex dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model(input int unsigned a, output int unsigned c,
                         output int unsigned gr, output int unsigned gc,
                         output int unsigned it);
        int unsigned y, x;
        y = a / 640;
        x = a % 640;
        if (y >= 240 && y < 480) begin
            it = 1;
            c  = ((y - 240) / 30) * 32 + x / 20;
            gr = (y - 240) % 30;
            gc = x % 20;
        end else begin
            it = 0;
            c  = 256;
            gr = 0;
            gc = 0;
        end
    endtask

    task automatic start(input int unsigned a);
        @(negedge clock);
        bus.address  = 19'(a);
        bus.in_valid = 1'b1;
        check("in_ready_idle", 32'(bus.in_ready), 1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.address  = 19'($urandom);
    endtask

    task automatic wait_result(input int unsigned a);
        int n;
        int unsigned c, gr, gc, it;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("latency", 32'(n), 29);
        model(a, c, gr, gc, it);
        check("count", bus.count, c);
        check("glyph_row", 32'(bus.glyph_row), gr);
        check("glyph_col", 32'(bus.glyph_col), gc);
        check("in_text", 32'(bus.in_text), it);
    endtask

    task automatic accept();
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        check("accept_out_valid", 32'(bus.out_valid), 0);
        check("accept_in_ready", 32'(bus.in_ready), 1);
    endtask

    task automatic convert(input int unsigned a, input int hold);
        int unsigned c, gr, gc, it;
        start(a);
        wait_result(a);
        model(a, c, gr, gc, it);
        repeat (hold) @(posedge clock);
        #1;
        check("held_count", bus.count, c);
        check("held_valid", 32'(bus.out_valid), 1);
        accept();
    endtask

    initial begin
        int unsigned c, gr, gc, it;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.address   = '0;
        #12;
        check("rst_count", bus.count, 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_in_text", 32'(bus.in_text), 0);
        @(negedge clock);
        reset = 1'b0;

        convert(153600, 0);
        convert(307199, 0);
        convert(183600, 1);
        convert(153599, 0);
        convert(307200, 0);
        convert(524287, 0);
        convert(0, 0);

        // backpressure with an ignored in_valid pulse while DONE
        start(153621);
        wait_result(153621);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.in_valid = (i == 2);
            bus.address  = 19'd0;
            check("bp_count", bus.count, 1);
            check("bp_glyph_col", 32'(bus.glyph_col), 1);
            check("bp_out_valid", 32'(bus.out_valid), 1);
            check("bp_in_ready", 32'(bus.in_ready), 0);
        end
        @(negedge clock);
        bus.in_valid = 1'b0;
        check("bp_after_count", bus.count, 1);
        accept();

        // reset in the middle of a conversion
        start(307199);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_in_text", 32'(bus.in_text), 0);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        check("mid_rst_glyph_row", 32'(bus.glyph_row), 0);
        @(negedge clock);
        reset = 1'b0;
        convert(153600, 0);

        for (int i = 0; i < 24; i++) begin
            int unsigned a;
            if (i % 2 == 0) a = $urandom_range(524287, 0);
            else a = $urandom_range(307199, 153600);
            convert(a, int'($urandom_range(3, 0)));
        end

        model(307199, c, gr, gc, it);
        check("model_sanity_top", c, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
